// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential divider: FSM state encoding and
// two's-complement utilities that work for any operand width up to MAX_W.
package div_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // All-ones mask covering the low 'width' bits (width = MAX_W gives all ones).
  function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
    logic [MAX_W:0] one_hot;
    one_hot = (MAX_W + 1)'(1) << width;
    return one_hot[MAX_W-1:0] - MAX_W'(1);
  endfunction

  // Two's-complement negation confined to 'width' bits.
  function automatic logic [MAX_W-1:0] neg2c(input logic [MAX_W-1:0] value,
                                             input int unsigned width);
    return (~value + MAX_W'(1)) & width_mask(width);
  endfunction

  // Magnitude of a 'width'-bit operand; MIN maps to 2^(width-1), which still
  // fits in 'width' unsigned bits.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                               input logic is_signed,
                                               input int unsigned width);
    logic neg;
    neg = is_signed & (|(value & (MAX_W'(1) << (width - 1))));
    return neg ? neg2c(value, width) : (value & width_mask(width));
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the ALU sequencer (master) and the divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider_restoring_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_restoring_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] diff;

  // Trial subtraction; the top bit of the widened difference is the borrow.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rem_out = '0;
    q_bit   = 1'b0;
    diff    = {rem_in, next_bit} - {2'b00, divisor_mag};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : {rem_in[WIDTH-1:0], next_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per cycle,
// with start/busy/done handshake and divide-by-zero / signed-overflow flags.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rstn,
  seq_divider_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_q;     // partial remainder, one extra bit for the borrow
  logic [WIDTH-1:0] acc;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_mag;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_pend;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_q),
    .next_bit    (acc[WIDTH-1]),
    .divisor_mag (dvs_mag),
    .rem_out     (rem_next),
    .q_bit       (q_bit)
  );

  // Operand sign and magnitude decode used on the capture edge.
  always_comb begin
    dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    dvd_abs = WIDTH'(abs_val(MAX_W'(bus.dividend), bus.is_signed, WIDTH));
    dvs_abs = WIDTH'(abs_val(MAX_W'(bus.divisor), bus.is_signed, WIDTH));
  end

  // Control FSM, iteration datapath and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      cnt             <= '0;
      rem_q           <= '0;
      acc             <= '0;
      dvs_mag         <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      ovf_pend        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.overflow    <= 1'b0;
            end else begin
              state    <= EXEC;
              bus.busy <= 1'b1;
              cnt      <= CNT_W'(WIDTH);
              rem_q    <= '0;
              acc      <= dvd_abs;
              dvs_mag  <= dvs_abs;
              q_neg    <= dvd_neg ^ dvs_neg;
              r_neg    <= dvd_neg;
              ovf_pend <= bus.is_signed && (bus.dividend == MIN_VAL) &&
                          (bus.divisor == '1);
            end
          end else begin
            state <= IDLE;
          end
        end

        EXEC: begin
          rem_q <= rem_next;
          acc   <= {acc[WIDTH-2:0], q_bit};
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIXUP;
          end
        end

        FIXUP: begin
          state           <= DONE;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.quotient    <= q_neg ? WIDTH'(neg2c(MAX_W'(acc), WIDTH)) : acc;
          bus.remainder   <= r_neg ? WIDTH'(neg2c(MAX_W'(rem_q[WIDTH-1:0]), WIDTH))
                                   : rem_q[WIDTH-1:0];
          bus.div_by_zero <= 1'b0;
          bus.overflow    <= ovf_pend;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 16-bit and 8-bit instances sharing clk/rstn.
module tb_seq_divider;

  logic clk;
  logic rstn;

  seq_divider_if #(.WIDTH(16)) bus16 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(16)) dut16 (.clk(clk), .rstn(rstn), .bus(bus16));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rstn(rstn), .bus(bus8));

  int tests_run    = 0;
  int tests_failed = 0;
  int edges;
  int busy_cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive a one-cycle start, then count rising edges after
  // the capture edge until done is seen (bounded).
  task automatic op16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    bus16.start     = 1'b1;
    bus16.is_signed = sgn;
    bus16.dividend  = a;
    bus16.divisor   = b;
    @(negedge clk);
    bus16.start     = 1'b0;
    bus16.dividend  = 16'hDEAD;
    bus16.divisor   = 16'h0003;
    bus16.is_signed = ~sgn;
    edges       = 0;
    busy_cycles = 0;
    while (!bus16.done && edges < 200) begin
      if (bus16.busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic op8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    bus8.start     = 1'b1;
    bus8.is_signed = sgn;
    bus8.dividend  = a;
    bus8.divisor   = b;
    @(negedge clk);
    bus8.start    = 1'b0;
    bus8.dividend = 8'h5A;
    bus8.divisor  = 8'h07;
    edges = 0;
    while (!bus8.done && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.dividend = '0; bus16.divisor = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst busy",      bus16.busy, 0);
    check("rst done",      bus16.done, 0);
    check("rst quotient",  bus16.quotient, 0);
    check("rst remainder", bus16.remainder, 0);
    check("rst dbz",       bus16.div_by_zero, 0);
    check("rst ovf",       bus16.overflow, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Unsigned 1000/7
    op16(1'b0, 16'd1000, 16'd7);
    check("u1000/7 latency",   edges, 17);
    check("u1000/7 busy cyc",  busy_cycles, 17);
    check("u1000/7 quotient",  bus16.quotient, 142);
    check("u1000/7 remainder", bus16.remainder, 6);
    check("u1000/7 dbz",       bus16.div_by_zero, 0);
    check("u1000/7 ovf",       bus16.overflow, 0);
    @(negedge clk);
    check("done one-cycle pulse", bus16.done, 0);
    check("quotient held",        bus16.quotient, 142);

    // Signed truncating division
    op16(1'b1, 16'hFFF9, 16'h0002);
    check("s-7/2 quotient",  bus16.quotient, 16'hFFFD);
    check("s-7/2 remainder", bus16.remainder, 16'hFFFF);
    @(negedge clk);
    op16(1'b1, 16'h0007, 16'hFFFE);
    check("s7/-2 quotient",  bus16.quotient, 16'hFFFD);
    check("s7/-2 remainder", bus16.remainder, 16'h0001);
    @(negedge clk);

    // Divide by zero
    op16(1'b0, 16'h1234, 16'h0000);
    check("dbz latency",   edges, 0);
    check("dbz busy",      bus16.busy, 0);
    check("dbz quotient",  bus16.quotient, 16'hFFFF);
    check("dbz remainder", bus16.remainder, 16'h1234);
    check("dbz flag",      bus16.div_by_zero, 1);
    @(negedge clk);
    op16(1'b0, 16'd10, 16'd3);
    check("10/3 dbz cleared", bus16.div_by_zero, 0);
    check("10/3 quotient",    bus16.quotient, 3);
    check("10/3 remainder",   bus16.remainder, 1);
    @(negedge clk);

    // Signed overflow MIN / -1, then same bits unsigned
    op16(1'b1, 16'h8000, 16'hFFFF);
    check("sovf quotient",  bus16.quotient, 16'h8000);
    check("sovf remainder", bus16.remainder, 0);
    check("sovf flag",      bus16.overflow, 1);
    @(negedge clk);
    op16(1'b0, 16'h8000, 16'hFFFF);
    check("u8000/FFFF quotient",  bus16.quotient, 0);
    check("u8000/FFFF remainder", bus16.remainder, 16'h8000);
    check("u8000/FFFF ovf",       bus16.overflow, 0);
    @(negedge clk);

    // Start held high through EXEC with changing operands is ignored
    bus16.start = 1'b1; bus16.is_signed = 1'b0;
    bus16.dividend = 16'd1000; bus16.divisor = 16'd7;
    @(negedge clk);
    bus16.dividend = 16'd5; bus16.divisor = 16'd5;
    edges = 0;
    while (!bus16.done && edges < 200) begin
      bus16.start = (edges < 10);
      @(negedge clk);
      edges++;
    end
    bus16.start = 1'b0;
    check("held-start latency",   edges, 17);
    check("held-start quotient",  bus16.quotient, 142);
    check("held-start remainder", bus16.remainder, 6);

    // Back-to-back: start issued in the DONE cycle
    op16(1'b0, 16'd100, 16'd9);
    check("b2b latency",   edges, 17);
    check("b2b quotient",  bus16.quotient, 11);
    check("b2b remainder", bus16.remainder, 1);
    @(negedge clk);

    // Reset mid-EXEC
    bus16.start = 1'b1; bus16.is_signed = 1'b0;
    bus16.dividend = 16'd1000; bus16.divisor = 16'd7;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort busy",      bus16.busy, 0);
    check("abort done",      bus16.done, 0);
    check("abort quotient",  bus16.quotient, 0);
    check("abort remainder", bus16.remainder, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("post-abort no done", bus16.done, 0);
    check("post-abort idle",    bus16.busy, 0);
    op16(1'b1, 16'hFF9C, 16'd7);
    check("post-abort latency",   edges, 17);
    check("post-abort quotient",  bus16.quotient, 16'hFFF2);
    check("post-abort remainder", bus16.remainder, 16'hFFFE);
    @(negedge clk);

    // 8-bit instance
    op8(1'b0, 8'd255, 8'd16);
    check("w8 255/16 latency",   edges, 9);
    check("w8 255/16 quotient",  bus8.quotient, 15);
    check("w8 255/16 remainder", bus8.remainder, 15);
    @(negedge clk);
    op8(1'b1, 8'h80, 8'h01);
    check("w8 s80/01 quotient",  bus8.quotient, 8'h80);
    check("w8 s80/01 remainder", bus8.remainder, 0);
    check("w8 s80/01 ovf",       bus8.overflow, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
